octo_frame_arbiter: RTL
=======================

Name: octo_frame_arbiter

Overview:
- Parametrised successor to the single-octo sensor path.
- Merges the frame outputs of NUM_CH octo managers into one buffered stream for the serial transmitter, using round-robin arbitration.
- Each captured frame is stamped with the free-running system timestamp and its source channel.
- Also owns the sys_ts counter and the aggregated configuration LEDs; sits between the octo managers and the UART.

Parameters:
- NUM_CH, 4, number of octo managers (≥1)
- FRAME_W, 272, bits per sensor_iterations frame
- TS_W, 24, timestamp width
- LEDS_PER_CH, 8, state LEDs per octo manager
- CH_W, $clog2(NUM_CH) (min 1), channel index width (derived, not overridden)

Ports:
- clk_96MHz  in  1  sole clock
- reset  in  1  synchronous, active-high
- data_avl  in  NUM_CH  per-channel frame-ready level, held until acked
- sensor_iterations  in  NUM_CH*FRAME_W  channel i at [i*FRAME_W +: FRAME_W]
- reset_parser  out  NUM_CH  one-cycle ack pulse to the captured channel
- state_leds  in  NUM_CH*LEDS_PER_CH  per-sensor configuration LEDs
- out_valid  out  1  buffered frame present
- out_ready  in  1  transmitter accepts frame
- out_frame  out  FRAME_W  buffered frame
- out_channel  out  CH_W  source channel of out_frame
- out_ts  out  TS_W  sys_ts at capture
- sys_ts  out  TS_W  free-running timestamp
- ts_wrap  out  1  high in the cycle sys_ts is all-ones
- stall_count  out  16  saturating back-pressure counter
- any_configured_led  out  1  OR of all state_leds
- all_configured_led  out  1  AND of all state_leds

Behaviour:
- Reset values (reset high at a clock edge):
  - sys_ts=0, out_valid=0, out_frame=0, out_channel=0, out_ts=0.
  - reset_parser=0, stall_count=0, ack mask=0, rr pointer=NUM_CH-1 (channel 0 wins first).
  - A buffered frame is discarded.
- sys_ts:
  - Increments every cycle; all-ones -> 0.
  - ts_wrap is combinational (sys_ts == all-ones).
- Eligibility:
  - Channel i is eligible when data_avl[i]=1 and ack_mask[i]=0.
  - ack_mask[i] is set in the cycle reset_parser[i] pulses and cleared on the first cycle data_avl[i] is seen low.
  - This prevents recapturing a frame whose data_avl is slow to fall.
- Load condition: load = (!out_valid || out_ready) && any eligible.
- On load (single clock edge):
  - Grant g = first eligible channel searching from rr_pter+1 modulo NUM_CH.
  - out_frame <= frame g, out_channel <= g, out_ts <= current sys_ts, out_valid <= 1.
  - reset_parser[g] = 1 for exactly that cycle (registered, visible the cycle after grant decision); rr_ptr <= g.
- Handshake:
  - A frame transfers when out_valid && out_ready.
  - With no load that cycle, out_valid <= 0 next cycle.
  - Transfer and load in the same cycle gives back-to-back output with out_valid staying 1: one frame per cycle maximum.
  - out_frame, out_channel and out_ts are stable while out_valid && !out_ready.
- Latency: eligible request with empty buffer -> out_valid high 1 cycle later.
- Fairness: with all channels requesting continuously, grants cycle 0,1,…,NUM_CH-1,0…
- NUM_CH=1: rr logic degenerates; out_channel stays 0.
- stall_count: increments by 1 each cycle where any channel is eligible && out_valid && !out_ready; saturates at 0xFFFF.
- LEDs: purely combinational, no reset dependency.
- Reset mid-transfer: the frame is lost and no reset_parser pulse is issued. A channel still holding data_avl is re-captured after reset.

Decomposition:
- Shared package octo_pkg holds:
  - default FRAME_W (272) and TS_W (24);
  - frame field offsets used by serial_transmitter;
  - a CH_W helper function.
- One natural sub-module: rr_arbiter (NUM_CH request in, one-hot grant + index out, pointer update on enable).

Test Plan:
- Reset, then idle 2^TS_W cycles (TS_W=8 build) -> sys_ts counts 0..255, ts_wrap high at 255, sys_ts=0 next.
- data_avl=4'b0100, frame=0xABC, out_ready=1 -> out_valid one cycle later, out_channel=2, out_frame=0xABC, out_ts=sys_ts of capture cycle, reset_parser=4'b0100 for one cycle.
- data_avl held high for 5 cycles after ack -> no second capture; drop data_avl, reassert -> captured again.
- All four channels request continuously, out_ready=1 -> grants 0,1,2,3,0,1, out_valid never drops.
- out_ready=0 for 10 cycles with channel 1 pending and buffer full -> outputs stable, stall_count=10, reset_parser stays 0; out_ready=1 -> channel 1 loaded back-to-back.
- state_leds all ones except one bit -> any_configured_led=1, all_configured_led=0; all zeros -> both 0.

Source files
------------

// File: rtl/octo_pkg.sv
// Shared definitions for the octo sensor path.
// Holds the default frame/timestamp widths, the field layout of a
// sensor_iterations frame (used by serial_transmitter when it serialises a
// buffered frame), and the channel-index width helper.
package octo_pkg;

  localparam int unsigned DEF_FRAME_W = 272;
  localparam int unsigned DEF_TS_W    = 24;
  localparam int unsigned STALL_W     = 16;

  // A frame is eight back-to-back sensor records, sensor 0 in the LSBs.
  localparam int unsigned SENSORS_PER_FRAME = 8;
  localparam int unsigned SENSOR_REC_W      = 34;

  // Layout of one sensor record inside its 34-bit slot.
  localparam int unsigned REC_DIST_OFS   = 0;
  localparam int unsigned REC_DIST_W     = 16;
  localparam int unsigned REC_AMPL_OFS   = 16;
  localparam int unsigned REC_AMPL_W     = 12;
  localparam int unsigned REC_STATUS_OFS = 28;
  localparam int unsigned REC_STATUS_W   = 6;

  // Bit offset of sensor record idx within a frame.
  function automatic int unsigned sensor_rec_ofs(input int unsigned idx);
    return idx * SENSOR_REC_W;
  endfunction

  // Channel index width; a single channel still gets one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/octo_frame_arbiter_if.sv
// Buffered output stream from the frame arbiter to the serial transmitter.
//   out_valid   : a buffered frame is present (driven by master)
//   out_ready   : transmitter accepts the frame this cycle (driven by slave)
//   out_frame   : buffered sensor_iterations frame
//   out_channel : source channel of out_frame
//   out_ts      : sys_ts sampled when the frame was captured
interface octo_frame_arbiter_if #(
  parameter int unsigned FRAME_W = 272,
  parameter int unsigned TS_W    = 24,
  parameter int unsigned CH_W    = 2
);

  logic               out_valid;
  logic               out_ready;
  logic [FRAME_W-1:0] out_frame;
  logic [CH_W-1:0]    out_channel;
  logic [TS_W-1:0]    out_ts;

  modport master (
    output out_valid,
    output out_frame,
    output out_channel,
    output out_ts,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_frame,
    input  out_channel,
    input  out_ts,
    output out_ready
  );

endinterface

// File: rtl/octo_frame_arbiter_rr_arbiter.sv
// Round-robin arbiter for the octo frame arbiter.
// Searches the request vector starting one past the last granted channel and
// moves the pointer to the winner whenever the grant is consumed.
//   clk_96MHz, reset : clock, synchronous active-high reset
//   req              : per-channel request
//   en               : grant is taken this cycle, advance the pointer
//   grant_oh_c       : one-hot grant (combinational)
//   grant_idx_c      : index of the grant (combinational)
//   grant_vld_c      : at least one request present (combinational)
module octo_frame_arbiter_rr_arbiter
  import octo_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = ch_width(NUM_CH)
) (
  input  logic              clk_96MHz,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] grant_oh_c,
  output logic [CH_W-1:0]   grant_idx_c,
  output logic              grant_vld_c
);

  logic [CH_W-1:0] rr_ptr;
  int unsigned     cand;

  // First requester after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    grant_idx_c = '0;
    grant_vld_c = 1'b0;
    cand        = 0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_CH;
      if (!grant_vld_c && req[CH_W'(cand)]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = CH_W'(cand);
      end
    end
  end

  assign grant_oh_c = grant_vld_c ? (NUM_CH'(1) << grant_idx_c) : '0;

  // Pointer starts at the last channel so channel 0 wins first after reset.
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      rr_ptr <= CH_W'(NUM_CH - 1);
    end else if (en && grant_vld_c) begin
      rr_ptr <= grant_idx_c;
    end
  end

endmodule

// File: rtl/octo_frame_arbiter.sv
// Merges the frame outputs of NUM_CH octo managers into one single-entry
// buffered stream for the serial transmitter, stamping each captured frame
// with sys_ts and its source channel. Also owns the free-running sys_ts
// counter, a back-pressure stall counter and the aggregated config LEDs.
//   clk_96MHz, reset   : clock, synchronous active-high reset
//   data_avl           : per-channel frame-ready level, held until acked
//   sensor_iterations  : channel i frame at [i*FRAME_W +: FRAME_W]
//   reset_parser       : one-cycle ack pulse to the captured channel
//   state_leds         : per-sensor configuration LEDs
//   out_if             : buffered output stream (valid/ready/frame/channel/ts)
//   sys_ts, ts_wrap    : free-running timestamp, high while sys_ts is all-ones
//   stall_count        : saturating count of back-pressured cycles
//   any/all_configured_led : OR / AND of all state_leds
module octo_frame_arbiter
  import octo_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned FRAME_W     = DEF_FRAME_W,
  parameter int unsigned TS_W        = DEF_TS_W,
  parameter int unsigned LEDS_PER_CH = 8
) (
  input  logic                          clk_96MHz,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             data_avl,
  input  logic [NUM_CH*FRAME_W-1:0]     sensor_iterations,
  output logic [NUM_CH-1:0]             reset_parser,
  input  logic [NUM_CH*LEDS_PER_CH-1:0] state_leds,
  octo_frame_arbiter_if.master          out_if,
  output logic [TS_W-1:0]               sys_ts,
  output logic                          ts_wrap,
  output logic [STALL_W-1:0]            stall_count,
  output logic                          any_configured_led,
  output logic                          all_configured_led
);

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic [FRAME_W-1:0] frame_arr [NUM_CH];
  logic [NUM_CH-1:0]  ack_mask;
  logic [NUM_CH-1:0]  eligible_c;
  logic               any_eligible_c;
  logic               load_c;
  logic [NUM_CH-1:0]  grant_oh_c;
  logic [CH_W-1:0]    grant_idx_c;
  logic               grant_vld_c;

  logic               out_valid_q;
  logic [FRAME_W-1:0] out_frame_q;
  logic [CH_W-1:0]    out_channel_q;
  logic [TS_W-1:0]    out_ts_q;

  // Split the flat frame bus into per-channel frames.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_split
    assign frame_arr[i] = sensor_iterations[i*FRAME_W +: FRAME_W];
  end

  // Free-running timestamp; wraps naturally from all-ones to zero.
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      sys_ts <= '0;
    end else begin
      sys_ts <= sys_ts + TS_W'(1);
    end
  end

  assign ts_wrap = &sys_ts;

  // A channel whose frame was already taken stays masked until its
  // data_avl is seen low, so a slowly falling level is not captured twice.
  assign eligible_c     = data_avl & ~ack_mask;
  assign any_eligible_c = |eligible_c;
  assign load_c         = (!out_valid_q || out_if.out_ready) && any_eligible_c;

  octo_frame_arbiter_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_arbiter (
    .clk_96MHz   (clk_96MHz),
    .reset       (reset),
    .req         (eligible_c),
    .en          (load_c),
    .grant_oh_c  (grant_oh_c),
    .grant_idx_c (grant_idx_c),
    .grant_vld_c (grant_vld_c)
  );

  // Ack mask set together with the reset_parser pulse, cleared by low data_avl.
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      ack_mask     <= '0;
      reset_parser <= '0;
    end else begin
      ack_mask     <= (ack_mask & data_avl) | (load_c ? grant_oh_c : '0);
      reset_parser <= load_c ? grant_oh_c : '0;
    end
  end

  // Single-entry output buffer; a load may replace a frame being transferred.
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_frame_q   <= '0;
      out_channel_q <= '0;
      out_ts_q      <= '0;
    end else if (load_c) begin
      out_valid_q   <= 1'b1;
      out_frame_q   <= frame_arr[grant_idx_c];
      out_channel_q <= grant_idx_c;
      out_ts_q      <= sys_ts;
    end else if (out_if.out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign out_if.out_valid   = out_valid_q;
  assign out_if.out_frame   = out_frame_q;
  assign out_if.out_channel = out_channel_q;
  assign out_if.out_ts      = out_ts_q;

  // Cycles where a channel is waiting behind a blocked buffer; saturates.
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      stall_count <= '0;
    end else if (any_eligible_c && out_valid_q && !out_if.out_ready &&
                 (stall_count != '1)) begin
      stall_count <= stall_count + STALL_W'(1);
    end
  end

  assign any_configured_led = |state_leds;
  assign all_configured_led = &state_leds;

endmodule
